shuffle_seq_ctrl: RTL and testbench

Stage sequencer for the 8-lane, 256-bit shuffle network in the 2D-array polynomial-multiply datapath. On `start` it walks a transform through `STAGES` stages of `BEATS` beats each. Every beat it drives the shuffle controls (`shuf_en`, `shuf_cros`, `shuf_ntt`) together with stage and beat indices. It stalls on back-pressure from the butterfly array and inserts `GAP` idle cycles after each stage to cover butterfly pipeline latency. It pulses `done` when the final results have drained.

---
 rtl/shuffle_seq_ctrl_if.sv | 34 +++
 rtl/shuffle_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_shuffle_seq_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/shuffle_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shuffle_seq_ctrl_if: start/abort/back-pressure and shuffle control  |
// | bundle between the stage sequencer and its environment.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface shuffle_seq_ctrl_if #(
  parameter int SW = 3,
  parameter int BW = 2
);
  logic          start;
  logic          mode_ntt;
  logic          clear;
  logic          pe_ready;
  logic          busy;
  logic          shuf_en;
  logic          shuf_cros;
  logic          shuf_ntt;
  logic [SW-1:0] stage_idx;
  logic [BW-1:0] beat_idx;
  logic          last_beat;
  logic          done;

  modport master (
    output start, mode_ntt, clear, pe_ready,
    input  busy, shuf_en, shuf_cros, shuf_ntt, stage_idx, beat_idx, last_beat, done
  );

  modport slave (
    input  start, mode_ntt, clear, pe_ready,
    output busy, shuf_en, shuf_cros, shuf_ntt, stage_idx, beat_idx, last_beat, done
  );
endinterface
`default_nettype wire

// File: rtl/shuffle_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shuffle_seq_ctrl: walks STAGES x BEATS shuffle beats with stalls,  |
// | per-stage idle gaps and a drain period, then pulses done.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module shuffle_seq_ctrl #(
  parameter int STAGES = 8,
  parameter int BEATS  = 4,
  parameter int GAP    = 2,
  parameter int XSTG   = 2,
  parameter int SW     = 3,
  parameter int BW     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  shuffle_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int              c_GW        = (GAP > 1) ? $clog2(GAP) : 1;
  localparam bit              c_HAS_GAP   = (GAP > 0);
  localparam logic [SW-1:0]   c_LAST_STG  = SW'(STAGES - 1);
  localparam logic [BW-1:0]   c_LAST_BEAT = BW'(BEATS - 1);
  localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'((GAP > 0) ? GAP - 1 : 0);

  state_t          r_state, w_state_nxt;
  logic            r_mode,  w_mode_nxt;
  logic [SW-1:0]   r_stage, w_stage_nxt;
  logic [BW-1:0]   r_beat,  w_beat_nxt;
  logic [c_GW-1:0] r_gap,   w_gap_nxt;

  logic            w_run;
  logic            w_stage_end;
  logic            w_final_stage;
  logic [SW-1:0]   w_stage_idx;

  assign w_stage_end   = (r_beat == c_LAST_BEAT);
  assign w_final_stage = (r_stage == c_LAST_STG);

  // Stage count resets to the last stage so that the down-counting
  // index seen with mode_r=0 reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_stage <= c_LAST_STG;
      r_beat  <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_stage <= w_stage_nxt;
      r_beat  <= w_beat_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_stage_nxt = r_stage;
    w_beat_nxt  = r_beat;
    w_gap_nxt   = r_gap;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_mode_nxt  = bus.mode_ntt;
          w_stage_nxt = '0;
          w_beat_nxt  = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.pe_ready) begin
          if (!w_stage_end) begin
            w_beat_nxt = r_beat + 1'b1;
          end else if (!w_final_stage) begin
            if (c_HAS_GAP) begin
              w_gap_nxt   = '0;
              w_state_nxt = S_GAP;
            end else begin
              w_stage_nxt = r_stage + 1'b1;
              w_beat_nxt  = '0;
            end
          end else begin
            w_gap_nxt   = '0;
            w_state_nxt = c_HAS_GAP ? S_DRAIN : S_DONE;
          end
        end
      end
      S_GAP: begin
        if (r_gap == c_GAP_LAST) begin
          w_stage_nxt = r_stage + 1'b1;
          w_beat_nxt  = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_gap == c_GAP_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Abort wins over everything, including a start seen in IDLE.
    if (bus.clear) begin
      w_state_nxt = S_IDLE;
      w_mode_nxt  = r_mode;
      w_stage_nxt = r_stage;
      w_beat_nxt  = r_beat;
    end
  end

  assign w_run       = (r_state == S_RUN);
  assign w_stage_idx = r_mode ? r_stage : (c_LAST_STG - r_stage);

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.shuf_en   = w_run;
  assign bus.shuf_ntt  = w_run & r_mode;
  assign bus.shuf_cros = w_run & r_beat[0] & (32'(w_stage_idx) < 32'(XSTG));
  assign bus.stage_idx = w_stage_idx;
  assign bus.beat_idx  = r_beat;
  assign bus.last_beat = w_run & w_final_stage & w_stage_end;
  assign bus.done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_shuffle_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_shuffle_seq_ctrl: vector table, directed corner sequences and   |
// | random stimulus against a beat-schedule reference model.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_shuffle_seq_ctrl;

  localparam int SA = 3, BA = 4, GA = 2, XA = 1;
  localparam int K_RUN = 1, K_GAP = 2, K_DONE = 3;

  typedef struct {int kind; int stg; int beat;} slot_t;
  typedef struct {bit st; bit pe; logic [5:0] ctl; int stg; int beat;} vec_t;
  typedef struct {logic [5:0] ctl; int stg; int beat;} vecb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shuffle_seq_ctrl_if #(.SW(2), .BW(2)) ifA ();
  shuffle_seq_ctrl_if #(.SW(1), .BW(1)) ifB ();

  shuffle_seq_ctrl #(.STAGES(SA), .BEATS(BA), .GAP(GA), .XSTG(XA), .SW(2), .BW(2)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA.slave));
  shuffle_seq_ctrl #(.STAGES(2), .BEATS(2), .GAP(0), .XSTG(2), .SW(1), .BW(1)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB.slave));

  logic [5:0] ctlA, ctlB;
  assign ctlA = {ifA.busy, ifA.shuf_en, ifA.shuf_cros, ifA.shuf_ntt, ifA.last_beat, ifA.done};
  assign ctlB = {ifB.busy, ifB.shuf_en, ifB.shuf_cros, ifB.shuf_ntt, ifB.last_beat, ifB.done};

  int    n_chk = 0;
  int    n_err = 0;
  slot_t q[$];
  bit    m_mode;
  vec_t  tbl[20];
  vecb_t tblb[6];

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: a transform is a list of scheduled cycles; RUN slots wait
  // for pe_ready, every other slot lasts exactly one cycle.
  task automatic model_reset();
    q.delete();
    m_mode = 1'b0;
  endtask

  task automatic model_update(input bit st, input bit md, input bit cl, input bit pe);
    if (cl) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (st) begin
        m_mode = md;
        for (int s = 0; s < SA; s++) begin
          for (int b = 0; b < BA; b++) q.push_back('{K_RUN, s, b});
          for (int g = 0; g < GA; g++) q.push_back('{K_GAP, s, 0});
        end
        q.push_back('{K_DONE, 0, 0});
      end
    end else if (!(q[0].kind == K_RUN && !pe)) begin
      void'(q.pop_front());
    end
  endtask

  task automatic model_check(input string nm);
    logic [5:0] ec;
    logic [1:0] es, eb;
    int         sidx;
    ec = '0; es = '0; eb = '0;
    if (q.size() != 0) begin
      case (q[0].kind)
        K_RUN: begin
          sidx = m_mode ? q[0].stg : SA - 1 - q[0].stg;
          ec = {1'b1, 1'b1, ((q[0].beat % 2) == 1) && (sidx < XA), m_mode,
                (q[0].stg == SA - 1) && (q[0].beat == BA - 1), 1'b0};
          es = 2'(sidx);
          eb = 2'(q[0].beat);
        end
        K_GAP:   ec = 6'b100000;
        default: ec = 6'b100001;
      endcase
    end
    cmp(nm, {6'b0, ctlA, ec[4] ? ifA.stage_idx : 2'b0, ec[4] ? ifA.beat_idx : 2'b0},
        {6'b0, ec, es, eb});
  endtask

  task automatic step(input bit st, input bit md, input bit cl, input bit pe);
    ifA.start = st; ifA.mode_ntt = md; ifA.clear = cl; ifA.pe_ready = pe;
    @(posedge clk);
    model_update(st, md, cl, pe);
    @(negedge clk);
    ifA.start = 1'b0; ifA.clear = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 6'b110100, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 6'b111100, 0, 1};
    tbl[2]  = '{1'b1, 1'b1, 6'b110100, 0, 2};
    tbl[3]  = '{1'b0, 1'b1, 6'b111100, 0, 3};
    tbl[4]  = '{1'b0, 1'b1, 6'b100000, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 6'b100000, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 6'b110100, 1, 0};
    tbl[7]  = '{1'b0, 1'b1, 6'b110100, 1, 1};
    tbl[8]  = '{1'b0, 1'b1, 6'b110100, 1, 2};
    tbl[9]  = '{1'b0, 1'b1, 6'b110100, 1, 3};
    tbl[10] = '{1'b0, 1'b1, 6'b100000, 0, 0};
    tbl[11] = '{1'b0, 1'b1, 6'b100000, 0, 0};
    tbl[12] = '{1'b0, 1'b1, 6'b110100, 2, 0};
    tbl[13] = '{1'b0, 1'b1, 6'b110100, 2, 1};
    tbl[14] = '{1'b0, 1'b1, 6'b110100, 2, 2};
    tbl[15] = '{1'b0, 1'b1, 6'b110110, 2, 3};
    tbl[16] = '{1'b0, 1'b1, 6'b100000, 0, 0};
    tbl[17] = '{1'b0, 1'b1, 6'b100000, 0, 0};
    tbl[18] = '{1'b0, 1'b1, 6'b100001, 0, 0};
    tbl[19] = '{1'b0, 1'b1, 6'b000000, 0, 0};
    tblb[0] = '{6'b110100, 0, 0};
    tblb[1] = '{6'b111100, 0, 1};
    tblb[2] = '{6'b110100, 1, 0};
    tblb[3] = '{6'b111110, 1, 1};
    tblb[4] = '{6'b100001, 0, 0};
    tblb[5] = '{6'b000000, 0, 0};

    ifA.start = 0; ifA.mode_ntt = 0; ifA.clear = 0; ifA.pe_ready = 1;
    ifB.start = 0; ifB.mode_ntt = 0; ifB.clear = 0; ifB.pe_ready = 1;
    model_reset();

    @(negedge clk);
    cmp("reset_A", {6'b0, ctlA, ifA.stage_idx, ifA.beat_idx}, 16'h0);
    cmp("reset_B", {8'b0, ctlB, ifB.stage_idx, ifB.beat_idx}, 16'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin step(0, 0, 0, 1); model_check("idle_after_reset"); end

    // Nominal NTT from the vector table; one extra start lands mid-RUN.
    for (int i = 0; i < 20; i++) begin
      logic [5:0] e;
      step(tbl[i].st, 1'b1, 1'b0, tbl[i].pe);
      e = tbl[i].ctl;
      cmp($sformatf("ntt_tbl_c%0d", i + 1),
          {6'b0, ctlA, e[4] ? ifA.stage_idx : 2'b0, e[4] ? ifA.beat_idx : 2'b0},
          {6'b0, e, 2'(tbl[i].stg), 2'(tbl[i].beat)});
    end

    // INTT ordering.
    step(1, 0, 0, 1);
    for (int k = 1; k <= 20; k++) begin model_check($sformatf("intt_c%0d", k)); step(0, 1, 0, 1); end

    // Back-pressure during cycles 2-4 moves done to cycle 22.
    step(1, 1, 0, 1);
    for (int k = 1; k <= 21; k++) begin
      model_check($sformatf("bp_c%0d", k));
      step(0, 1, 0, (k >= 2 && k <= 4) ? 1'b0 : 1'b1);
    end
    cmp("bp_done_c22", {15'b0, ifA.done}, 16'h1);
    model_check("bp_c22");
    step(0, 1, 0, 1);
    model_check("bp_c23");

    // Abort: ignored start in RUN, clear in cycle 8.
    step(1, 1, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      model_check($sformatf("abort_c%0d", k));
      step(k == 3, 0, k == 8, 1);
    end
    cmp("abort_c9_busy_en", {14'b0, ifA.busy, ifA.shuf_en}, 16'h0);
    for (int k = 9; k <= 14; k++) begin model_check($sformatf("abort_idle_c%0d", k)); step(0, 0, 0, 1); end
    step(1, 0, 0, 1);
    for (int k = 1; k <= 20; k++) begin model_check($sformatf("rerun_c%0d", k)); step(0, 0, 0, 1); end

    // Clear together with start in IDLE keeps the block idle.
    step(1, 1, 1, 1);
    model_check("clear_start_idle");
    step(0, 1, 0, 1);
    model_check("clear_start_idle2");

    // Asynchronous reset in cycle 10.
    step(1, 1, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      model_check($sformatf("prereset_c%0d", k));
      if (k < 10) step(0, 1, 0, 1);
    end
    rst_n = 1'b0;
    #1;
    cmp("async_reset_A", {6'b0, ctlA, ifA.stage_idx, ifA.beat_idx}, 16'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin step(0, 1, 0, 1); model_check("post_reset_idle"); end
    step(1, 1, 0, 1);
    for (int k = 1; k <= 20; k++) begin model_check($sformatf("post_reset_run_c%0d", k)); step(0, 1, 0, 1); end

    // GAP=0 instance from its own table.
    ifB.start = 1'b1; ifB.mode_ntt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifB.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [5:0] e;
      e = tblb[i].ctl;
      cmp($sformatf("gap0_c%0d", i + 1),
          {8'b0, ctlB, e[4] ? ifB.stage_idx : 1'b0, e[4] ? ifB.beat_idx : 1'b0},
          {8'b0, e, 1'(tblb[i].stg), 1'(tblb[i].beat)});
      @(posedge clk);
      @(negedge clk);
    end

    // Random traffic on the main instance.
    for (int k = 0; k < 700; k++) begin
      step(($urandom % 6) == 0, 1'($urandom), ($urandom % 60) == 0, ($urandom % 4) != 0);
      model_check($sformatf("rand_%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
